// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory read port among NREQ BIUs; fixed priority when ARB_FIXED_PRIO_EN is defined, else round-robin
module bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int MAX_OST = 8,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    biu2arb_req,
  input  logic [NREQ*AW-1:0] biu2arb_addr,
  input  logic [NREQ-1:0]    biu2arb_vld,
  output logic [NREQ-1:0]    biu2arb_rdy,
  output logic [AW-1:0]      arb2biu_addr,
  output logic [DW-1:0]      arb2biu_data,
  output logic [NREQ-1:0]    arb2biu_vld,
  input  logic [NREQ-1:0]    arb2biu_rdy,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_vld,
  input  logic               mem_rdy,
  input  logic [AW-1:0]      mem_rsp_addr,
  input  logic [DW-1:0]      mem_rsp_data,
  input  logic               mem_rsp_vld,
  output logic               mem_rsp_rdy,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(MAX_OST) + 1;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [PW-1:0]   own, win_idx, idx;
  logic [OW-1:0]   ost;
  logic            addr_en, rsp_en, addr_hs, rsp_hs;
`ifndef ARB_FIXED_PRIO_EN
  logic [PW-1:0]   rr_ptr;
`endif
  // winner search: scanning from the lowest-priority slot down leaves the highest-priority requester
  always_comb begin
    win_idx = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ARB_FIXED_PRIO_EN
      idx = PW'(k);
`else
      idx = PW'((int'(rr_ptr) + k) % NREQ);
`endif
      win_idx = biu2arb_req[idx] ? idx : win_idx;
    end
  end
  // state, owner, pointer and outstanding-beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      own   <= '0;
      ost   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ost   <= ost + OW'(addr_hs) - OW'(rsp_hs);
      if (state == IDLE) own <= win_idx;
`ifndef ARB_FIXED_PRIO_EN
      if (state == IDLE && |biu2arb_req) rr_ptr <= win_idx == PW'(NREQ - 1) ? '0 : win_idx + PW'(1);
`endif
    end
  end
  // next state: hold grant until the owner releases and every outstanding beat has returned
  always_comb begin
    state_nxt = state == IDLE  ? (|biu2arb_req ? GRANT : IDLE) :
                state == GRANT ? (biu2arb_req[own] ? GRANT : (ost == '0 ? IDLE : DRAIN)) :
                (ost == '0 || (ost == OW'(1) && rsp_hs)) ? IDLE : DRAIN;
    grant_nxt = state_nxt == IDLE ? '0 : state == IDLE ? NREQ'(1) << win_idx : grant;
  end
  // outputs: address path only while the owner still requests and the beat budget allows
  always_comb begin
    addr_en      = state == GRANT && biu2arb_req[own] && ost != OW'(MAX_OST);
    rsp_en       = state != IDLE;
    mem_addr     = biu2arb_addr[own*AW +: AW];
    mem_vld      = addr_en && biu2arb_vld[own];
    biu2arb_rdy  = grant & {NREQ{addr_en && mem_rdy}};
    arb2biu_vld  = grant & {NREQ{rsp_en && mem_rsp_vld}};
    mem_rsp_rdy  = rsp_en && arb2biu_rdy[own];
    arb2biu_addr = mem_rsp_addr;
    arb2biu_data = mem_rsp_data;
    busy         = rsp_en;
    addr_hs      = mem_vld && mem_rdy;
    rsp_hs       = mem_rsp_vld && mem_rsp_rdy;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table plus multi-cycle sequences for bus_arbiter (round-robin build)
module tb_bus_arbiter;
  localparam int NREQ = 3, AW = 32, DW = 32, MAX_OST = 8;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    biu2arb_req, biu2arb_vld, biu2arb_rdy, arb2biu_vld, arb2biu_rdy, grant;
  logic [NREQ*AW-1:0] biu2arb_addr;
  logic [AW-1:0]      arb2biu_addr, mem_addr, mem_rsp_addr;
  logic [DW-1:0]      arb2biu_data, mem_rsp_data;
  logic               mem_vld, mem_rdy, mem_rsp_vld, mem_rsp_rdy, busy;
  int checks = 0, failures = 0;

  bus_arbiter #(.NREQ(NREQ), .MAX_OST(MAX_OST), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .biu2arb_req(biu2arb_req), .biu2arb_addr(biu2arb_addr), .biu2arb_vld(biu2arb_vld), .biu2arb_rdy(biu2arb_rdy),
    .arb2biu_addr(arb2biu_addr), .arb2biu_data(arb2biu_data), .arb2biu_vld(arb2biu_vld), .arb2biu_rdy(arb2biu_rdy),
    .mem_addr(mem_addr), .mem_vld(mem_vld), .mem_rdy(mem_rdy),
    .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data), .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  assign biu2arb_addr = {32'hA000_0200, 32'hA000_0100, 32'hA000_0000};

  typedef struct {
    logic       rst;
    logic [2:0] req, vld;
    logic       mrdy, rsp;
    logic [2:0] ardy;
    logic [2:0] g;
    logic       busy, mvld;
    logic [2:0] brdy, avld;
    logic       mrr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] req, input logic [2:0] vld, input logic mrdy,
                              input logic rsp, input logic [2:0] ardy, input logic [2:0] g, input logic b,
                              input logic mvld, input logic [2:0] brdy, input logic [2:0] avld, input logic mrr);
    vec_t v;
    v.rst = r; v.req = req; v.vld = vld; v.mrdy = mrdy; v.rsp = rsp; v.ardy = ardy;
    v.g = g; v.busy = b; v.mvld = mvld; v.brdy = brdy; v.avld = avld; v.mrr = mrr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc, hs, owner;
  bit done;

  initial begin
    rst = 1'b1; biu2arb_req = '0; biu2arb_vld = '0; arb2biu_rdy = '0;
    mem_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_addr = '0; mem_rsp_data = '0;
    step(); step();
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_vld", {mem_vld, mem_rsp_rdy, biu2arb_rdy, arb2biu_vld}, 0);
    rst = 1'b0;
    // single requester: 4 beats (one stalled by mem_rdy), 4 responses (one stalled by arb2biu_rdy), release
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 0, 3'b111, 3'b001, 1, 1, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 3'b111, 3'b001, 1, 1, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 0, 3'b111, 3'b001, 1, 1, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 0, 3'b111, 3'b001, 1, 1, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 0, 3'b111, 3'b001, 1, 1, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 1, 3'b111, 3'b001, 1, 0, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 1, 3'b110, 3'b001, 1, 0, 3'b001, 3'b001, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 1, 3'b111, 3'b001, 1, 0, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 1, 3'b111, 3'b001, 1, 0, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 1, 3'b111, 3'b001, 1, 0, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 0, 3'b111, 3'b001, 1, 0, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 1, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    // round-robin: all request, each owner issues one beat, gets its response, drops and re-raises
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 1, 0, 3'b111, 3'b001, 1, 1, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 1, 3'b111, 3'b001, 1, 0, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b110, 3'b000, 1, 0, 3'b111, 3'b001, 1, 0, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 1, 0, 3'b111, 3'b010, 1, 1, 3'b010, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 1, 3'b111, 3'b010, 1, 0, 3'b010, 3'b010, 1));
    tbl.push_back(mk(0, 3'b101, 3'b000, 1, 0, 3'b111, 3'b010, 1, 0, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b111, 1, 0, 3'b111, 3'b100, 1, 1, 3'b100, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 1, 3'b111, 3'b100, 1, 0, 3'b100, 3'b100, 1));
    tbl.push_back(mk(0, 3'b011, 3'b000, 1, 0, 3'b111, 3'b100, 1, 0, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 3'b111, 3'b001, 1, 0, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 0, 3'b111, 3'b001, 1, 0, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 0, 3'b111, 3'b000, 0, 0, 3'b000, 3'b000, 0));
    foreach (tbl[i]) begin
      rst = tbl[i].rst; biu2arb_req = tbl[i].req; biu2arb_vld = tbl[i].vld; mem_rdy = tbl[i].mrdy;
      mem_rsp_vld = tbl[i].rsp; arb2biu_rdy = tbl[i].ardy;
      mem_rsp_addr = $urandom; mem_rsp_data = $urandom;
      #1;
      chk($sformatf("v%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_mem_vld", i), mem_vld, tbl[i].mvld);
      chk($sformatf("v%0d_biu_rdy", i), biu2arb_rdy, tbl[i].brdy);
      chk($sformatf("v%0d_arb_vld", i), arb2biu_vld, tbl[i].avld);
      chk($sformatf("v%0d_rsp_rdy", i), mem_rsp_rdy, tbl[i].mrr);
      if (tbl[i].mvld) begin
        owner = tbl[i].g[0] ? 0 : tbl[i].g[1] ? 1 : 2;
        chk($sformatf("v%0d_mem_addr", i), mem_addr, 32'hA000_0000 + owner * 32'h100);
      end
      if (tbl[i].avld != 0) begin
        chk($sformatf("v%0d_rsp_data", i), arb2biu_data, mem_rsp_data);
        chk($sformatf("v%0d_rsp_addr", i), arb2biu_addr, mem_rsp_addr);
      end
      step();
    end
    // back-pressure at MAX_OST
    rst = 1'b1; biu2arb_req = '0; biu2arb_vld = '0; mem_rsp_vld = 1'b0; arb2biu_rdy = 3'b111; mem_rdy = 1'b1;
    step();
    rst = 1'b0; biu2arb_req = 3'b001;
    step();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      biu2arb_vld = 3'b001;
      #1;
      if (mem_vld && mem_rdy) acc++;
      if (i >= 8) begin
        chk("bp_mem_vld_full", mem_vld, 0);
        chk("bp_biu_rdy_full", biu2arb_rdy, 0);
      end
      step();
    end
    chk("bp_accepted", acc, 8);
    mem_rsp_vld = 1'b1;
    #1;
    chk("bp_still_full", mem_vld, 0);
    chk("bp_rsp_rdy", mem_rsp_rdy, 1);
    step();
    mem_rsp_vld = 1'b0;
    #1;
    chk("bp_resume", mem_vld, 1);
    step();
    // simultaneous issue and response at ost=5
    biu2arb_vld = 3'b000; mem_rsp_vld = 1'b1;
    for (int i = 0; i < 3; i++) step();
    biu2arb_vld = 3'b001;
    #1;
    chk("sim_mem_vld", mem_vld, 1);
    chk("sim_rsp_rdy", mem_rsp_rdy, 1);
    step();
    mem_rsp_vld = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_vld && mem_rdy) acc++;
      step();
    end
    chk("sim_ost_kept", acc, 3);
    // drain with toggling response ready while requester 1 waits
    biu2arb_vld = 3'b000; mem_rsp_vld = 1'b1;
    for (int i = 0; i < 5; i++) step();
    biu2arb_req = 3'b010; biu2arb_vld = 3'b001; hs = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      arb2biu_rdy = {2'b11, k[0]};
      #1;
      if (!busy) done = 1'b1;
      else begin
        chk("drain_grant", grant, 3'b001);
        chk("drain_mem_vld", mem_vld, 0);
        if (mem_rsp_rdy && mem_rsp_vld) hs++;
        step();
      end
    end
    chk("drain_done", done, 1);
    chk("drain_hs", hs, 3);
    chk("drain_idle_grant", grant, 0);
    step();
    chk("drain_next_owner", grant, 3'b010);
    // reset mid-GRANT with 4 beats outstanding
    mem_rsp_vld = 1'b0; biu2arb_vld = 3'b010; acc = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_vld && mem_rdy) acc++;
      step();
    end
    chk("rst_pre_beats", acc, 4);
    mem_rsp_vld = 1'b1; arb2biu_rdy = 3'b111; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", {mem_vld, mem_rsp_rdy, biu2arb_rdy, arb2biu_vld}, 0);
    step();
    mem_rsp_vld = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_vld && mem_rdy) acc++;
      step();
    end
    chk("rst_ost_cleared", acc, 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory read port among NREQ bus interface units: imap, weight and omap BIUs.
- Sits between the BIUs and the memory interface.
- Grants the bus to one requester at a time, either round-robin or fixed priority.
- Forwards the granted requester's address beats, and routes read responses back to the owner.
- Holds the grant until the owner drops its request and all of its outstanding responses have returned.

Parameters:
- NREQ, 3, number of requesters (index 0=imap, 1=weight, 2=omap).
- MAX_OST, 8, maximum outstanding read beats; must be a power of 2 and at most 16.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- biu2arb_req  in  NREQ  per-requester bus request, held for the whole burst
- biu2arb_addr  in  NREQ*AW  per-requester read address, requester i in bits [i*AW +: AW]
- biu2arb_vld  in  NREQ  per-requester address valid
- biu2arb_rdy  out  NREQ  per-requester address ready
- arb2biu_addr  out  AW  response address, broadcast to all requesters
- arb2biu_data  out  DW  response data, broadcast to all requesters
- arb2biu_vld  out  NREQ  per-requester response valid
- arb2biu_rdy  in  NREQ  per-requester response ready
- mem_addr  out  AW  memory read address
- mem_vld  out  1  memory address valid
- mem_rdy  in  1  memory address ready
- mem_rsp_addr  in  AW  memory response address
- mem_rsp_data  in  DW  memory response data
- mem_rsp_vld  in  1  memory response valid
- mem_rsp_rdy  out  1  memory response ready
- grant  out  NREQ  one-hot current owner; 0 when idle
- busy  out  1  high in GRANT or DRAIN

Behaviour:
- Reset values:
  - state=IDLE, grant=0, busy=0.
  - rr_ptr=0; outstanding count ost=0.
  - All vld/rdy outputs are 0.
  - mem_addr, arb2biu_addr and arb2biu_data are combinational muxes of their inputs and are don't-care while their vld is 0.
- IDLE:
  - If any biu2arb_req bit is set, select a winner and register it into grant.
  - Next state is GRANT, so grant asserts one cycle after req.
  - No address is forwarded in the cycle the winner is chosen.
- Round-robin arbitration:
  - Search starts at rr_ptr and wraps modulo NREQ.
  - The first set req bit wins.
  - On grant, rr_ptr = winner+1 mod NREQ.
- GRANT, address path (owner w):
  - mem_vld = biu2arb_vld[w] && (ost != MAX_OST).
  - mem_addr = biu2arb_addr[w].
  - biu2arb_rdy[w] = mem_rdy && (ost != MAX_OST).
  - All other rdy bits are 0.
- GRANT/DRAIN, response path:
  - arb2biu_vld[w] = mem_rsp_vld; all other vld bits are 0.
  - mem_rsp_rdy = arb2biu_rdy[w].
  - Address and data pass straight through, with zero added latency.
- Outstanding count:
  - ost increments on an address handshake (mem_vld && mem_rdy).
  - ost decrements on a response handshake (mem_rsp_vld && mem_rsp_rdy).
  - Both in the same cycle leaves ost unchanged.
  - ost is $clog2(MAX_OST)+1 bits wide and never exceeds MAX_OST.
- Release path:
  - In GRANT, when biu2arb_req[w]=0, go to DRAIN; the address path is gated off (mem_vld=0, biu2arb_rdy=0).
  - In DRAIN, when ost==0, or ost==1 with a response handshake this cycle, go to IDLE and clear grant.
  - In GRANT, if req[w]=0 and ost is already 0, go directly to IDLE.
  - In IDLE, response vld bits are 0 and mem_rsp_rdy=0.
- Re-request: the owner re-raising req during DRAIN does not cancel DRAIN; it re-arbitrates in IDLE.
- Minimum idle gap between owners is one cycle (the IDLE cycle).
- Responses arriving in IDLE (protocol violation) are not accepted, and ost stays 0.
- rst mid-operation:
  - Abandons all outstanding beats and returns to the reset state next cycle.
  - The memory side must be reset together with this block.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (imap > weight > omap); rr_ptr is removed.
- Undefined: round-robin as specified in Behaviour.
- Grant-hold and drain rules are identical in both modes.

Test Plan:
- Single requester: req[0]=1, 4 address beats with mem_rdy=1, 4 responses.
  - grant=3'b001 one cycle after req.
  - mem_addr follows biu2arb_addr[0].
  - arb2biu_vld[0] asserts for 4 beats.
  - IDLE one cycle after req drops with ost=0.
- Round-robin: req=3'b111 held, each owner issues 1 beat, then drops and re-raises req.
  - Grant order is 001, 010, 100, 001.
  - With ARB_FIXED_PRIO_EN defined, the order is 001, 001, ...
- Back-pressure at MAX_OST: mem_rdy=1, responses withheld, 10 beats offered.
  - Exactly 8 accepted; mem_vld=0 and biu2arb_rdy=0 while ost=8.
  - One response handshake resumes issue.
- Drain: owner drops req with ost=3 and arb2biu_rdy toggling.
  - State stays DRAIN; no new grant while req[1] is high.
  - Enters IDLE after the 3rd response handshake; grants requester 1 the next cycle.
- Simultaneous issue and response at ost=5: ost stays 5.
- Reset mid-GRANT with ost=4: next cycle grant=0, busy=0, ost=0, and all vld outputs are 0.
